// File: rtl/tdm_demux2.sv
// Two-slot TDM demultiplexer: hunts for frame sync, locks after repeated aligned
// syncs, and presents recovered {ch0, ch1} word pairs behind a valid/ready register.
module tdm_demux2 #(
   parameter int WIDTH      = 8,
   parameter int LOCK_COUNT = 4,
   parameter int MISS_LIMIT = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             frame_sync,
   output logic [WIDTH-1:0] ch0_data,
   output logic [WIDTH-1:0] ch1_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             locked,
   output logic             sync_err,
   output logic             overflow
);

   typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

   localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
   localparam logic [3:0] MISS_N = 4'(MISS_LIMIT);

   state_t           state_q, state_d;
   logic             phase_q, phase_d;   // 0: next accepted beat is slot 0
   logic [3:0]       match_q, match_d;
   logic [3:0]       miss_q, miss_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [WIDTH-1:0] ch0_d, ch1_d;
   logic             valid_d, sync_err_d, overflow_d;
   logic             pair_done, mismatch;

   assign locked = (state_q == LOCKED);

   // NOTE: every signal written here gets a default first, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      match_d    = match_q;
      miss_d     = miss_q;
      hold_d     = hold_q;
      ch0_d      = ch0_data;
      ch1_d      = ch1_data;
      valid_d    = out_valid;
      sync_err_d = 1'b0;
      overflow_d = 1'b0;
      pair_done  = 1'b0;
      mismatch   = 1'b0;

      if (din_valid) begin
         unique case (state_q)
            HUNT: begin
               if (frame_sync) begin
                  hold_d  = din;
                  phase_d = 1'b1;
                  match_d = 4'd1;
                  state_d = CHECK;
               end
            end
            CHECK: begin
               if (!phase_q) begin
                  hold_d = din;
                  if (frame_sync) begin
                     phase_d = 1'b1;
                     match_d = match_q + 4'd1;
                     if (match_q + 4'd1 == LOCK_N) begin
                        state_d = LOCKED;
                        miss_d  = 4'd0;
                     end
                  end else begin
                     state_d = HUNT;
                     phase_d = 1'b0;
                     match_d = 4'd0;
                  end
               end else if (frame_sync) begin
                  // Sync landed on slot 1: restart alignment from this beat.
                  hold_d  = din;
                  phase_d = 1'b1;
                  match_d = 4'd1;
               end else begin
                  phase_d = 1'b0;
               end
            end
            LOCKED: begin
               phase_d  = ~phase_q;
               mismatch = (phase_q == frame_sync);
               if (!phase_q) hold_d = din;
               else          pair_done = 1'b1;
               if (!phase_q && frame_sync) miss_d = 4'd0;
               if (mismatch) begin
                  sync_err_d = 1'b1;
                  miss_d     = miss_q + 4'd1;
                  if (miss_q + 4'd1 == MISS_N) begin
                     state_d = HUNT;
                     phase_d = 1'b0;
                     match_d = 4'd0;
                     miss_d  = 4'd0;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end

      // A new pair may replace the held one only if that one leaves this cycle.
      if (pair_done) begin
         if (!out_valid || out_ready) begin
            ch0_d   = hold_q;
            ch1_d   = din;
            valid_d = 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end else if (out_valid && out_ready) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from the values computed before the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= HUNT;
         phase_q   <= 1'b0;
         match_q   <= 4'd0;
         miss_q    <= 4'd0;
         hold_q    <= '0;
         ch0_data  <= '0;
         ch1_data  <= '0;
         out_valid <= 1'b0;
         sync_err  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         match_q   <= match_d;
         miss_q    <= miss_d;
         hold_q    <= hold_d;
         ch0_data  <= ch0_d;
         ch1_data  <= ch1_d;
         out_valid <= valid_d;
         sync_err  <= sync_err_d;
         overflow  <= overflow_d;
      end
   end

endmodule
